// File: rtl/foo_lift_pkg.sv
// Shared types for the lift feeder: the queued operand pair, the captured
// result, and the reference OR that the partial block is expected to compute.
package foo_lift_pkg;

  // One queued operand pair; both operands are full 2-bit values.
  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } pair_t;

  // Result captured from the partial block when the head entry is consumed.
  typedef struct packed {
    logic [1:0] o;
    logic       err;
  } result_t;

  // What {O3,O0} must equal for a healthy partial block.
  function automatic logic [1:0] lift_ref(input pair_t p);
    return p.a | p.b;
  endfunction

endpackage

// File: rtl/foo_lift_fifo.sv
// Circular operand-pair queue. Ready/valid are decoded purely from the
// registered occupancy count, so neither depends on this cycle's inputs and
// a push into an empty queue is visible on the output one cycle later.
module foo_lift_fifo
  import foo_lift_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  CLK,
  input  logic  RESET,
  input  logic  in_valid,
  output logic  in_ready,
  input  pair_t in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output pair_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_BITS-1:0] count;
  pair_t               mem [DEPTH];

  logic push;
  logic pop;

  assign in_ready  = (count != CNT_BITS'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge CLK) begin
    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it has been written, so clearing it buys nothing.
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/foo_lift_feeder.sv
// Feeds queued operand pairs to a combinational "partial" block one bit-plane
// at a time (bit0 on I0/I1, bit1 on the lifted inputs), and when the head is
// consumed captures the partial's outputs and checks them for consistency.
module foo_lift_feeder
  import foo_lift_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_I0,
  input  logic [1:0]       in_I1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       I0,
  output logic [1:0]       I1,
  output logic             lifted_input0,
  output logic             lifted_input1,
  input  logic             O0,
  input  logic             O2,
  input  logic             O3,
  input  logic             lifted_output_0,
  output logic             res_valid,
  output logic [1:0]       res_O,
  output logic             res_err,
  output logic [CNT_W-1:0] txn_count
);

  pair_t   in_pair;
  pair_t   head;
  result_t cap;
  result_t res_reg;
  logic    pop;

  assign in_pair.a = in_I0;
  assign in_pair.b = in_I1;

  foo_lift_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pair),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .head     (head)
  );

  assign pop = out_valid & out_ready;

  // Present the head's bit-planes to the partial; idle lines are held at 0.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    I0            = 2'b00;
    I1            = 2'b00;
    lifted_input0 = 1'b0;
    lifted_input1 = 1'b0;
    if (out_valid) begin
      I0            = {1'b0, head.a[0]};
      I1            = {1'b0, head.b[0]};
      lifted_input0 = head.a[1];
      lifted_input1 = head.b[1];
    end
  end

  // Evaluate the partial's returns against the head operands.
  always_comb begin
    cap.o   = {O3, O0};
    cap.err = (O2 != ~O0) || (lifted_output_0 != O0) || ({O3, O0} != lift_ref(head));
  end

  // Capture the checked result and count transactions on each pop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      res_valid <= 1'b0;
      res_reg   <= '0;
      txn_count <= '0;
    end else begin
      res_valid <= pop;
      if (pop) begin
        res_reg   <= cap;
        txn_count <= txn_count + CNT_W'(1);
      end
    end
  end

  assign res_O   = res_reg.o;
  assign res_err = res_reg.err;

endmodule

// File: tb/tb_foo_lift_feeder.sv
// Bench for foo_lift_feeder (DEPTH=2, CNT_W=2). A negedge monitor keeps a
// scoreboard of queued pairs and pending results; scenario tasks add their
// own directed comparisons.
module tb_foo_lift_feeder;
  import foo_lift_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_I0;
  logic [1:0]       in_I1;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       I0;
  logic [1:0]       I1;
  logic             lifted_input0;
  logic             lifted_input1;
  logic             O0;
  logic             O2;
  logic             O3;
  logic             lifted_output_0;
  logic             res_valid;
  logic [1:0]       res_O;
  logic             res_err;
  logic [CNT_W-1:0] txn_count;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  bit fault_mode = 1'b0;

  // Scoreboard state.
  pair_t      exp_q[$];
  result_t    res_q[$];
  logic       exp_res_valid = 1'b0;
  logic [1:0] exp_txn = 2'd0;

  always #5 CLK = ~CLK;

  foo_lift_feeder #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_I0          (in_I0),
    .in_I1          (in_I1),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .I0             (I0),
    .I1             (I1),
    .lifted_input0  (lifted_input0),
    .lifted_input1  (lifted_input1),
    .O0             (O0),
    .O2             (O2),
    .O3             (O3),
    .lifted_output_0(lifted_output_0),
    .res_valid      (res_valid),
    .res_O          (res_O),
    .res_err        (res_err),
    .txn_count      (txn_count)
  );

  // Behavioural partial block: OR of the two bit-planes, with an optional
  // stuck-at-0 fault on lifted_output_0.
  assign O0              = I0[0] | I1[0];
  assign O3              = lifted_input0 | lifted_input1;
  assign O2              = ~O0;
  assign lifted_output_0 = fault_mode ? 1'b0 : O0;

  // Scoreboard monitor: check what the last edge produced, then predict the next.
  always @(negedge CLK) begin
    if (mon_en) begin
      bit      do_push;
      bit      do_pop;
      pair_t   p;
      result_t r;
      vectors++;
      if (res_valid !== exp_res_valid) begin
        miscompares++;
        $display("FAIL mon_res_valid: got %b expected %b @%0t", res_valid, exp_res_valid, $time);
      end
      if (exp_res_valid && res_q.size() != 0) begin
        r = res_q.pop_front();
        vectors++;
        if (res_O !== r.o || res_err !== r.err) begin
          miscompares++;
          $display("FAIL mon_result: got O=%b err=%b expected O=%b err=%b @%0t",
                   res_O, res_err, r.o, r.err, $time);
        end
      end
      vectors++;
      if (txn_count !== exp_txn) begin
        miscompares++;
        $display("FAIL mon_txn_count: got %0d expected %0d @%0t", txn_count, exp_txn, $time);
      end
      vectors++;
      if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() != DEPTH)) begin
        miscompares++;
        $display("FAIL mon_flags: got out_valid=%b in_ready=%b expected occupancy %0d @%0t",
                 out_valid, in_ready, exp_q.size(), $time);
      end
      vectors++;
      if (exp_q.size() != 0) begin
        p = exp_q[0];
        if (I0 !== {1'b0, p.a[0]} || I1 !== {1'b0, p.b[0]} ||
            lifted_input0 !== p.a[1] || lifted_input1 !== p.b[1]) begin
          miscompares++;
          $display("FAIL mon_head: got I0=%b I1=%b L0=%b L1=%b expected a=%b b=%b @%0t",
                   I0, I1, lifted_input0, lifted_input1, p.a, p.b, $time);
        end
      end else if (I0 !== 2'b00 || I1 !== 2'b00 || lifted_input0 !== 1'b0 || lifted_input1 !== 1'b0) begin
        miscompares++;
        $display("FAIL mon_idle_lines: got I0=%b I1=%b L0=%b L1=%b expected all 0 @%0t",
                 I0, I1, lifted_input0, lifted_input1, $time);
      end
      // Predict the effect of the coming edge.
      if (RESET) begin
        exp_q.delete();
        res_q.delete();
        exp_res_valid = 1'b0;
        exp_txn       = 2'd0;
      end else begin
        do_pop  = out_ready && (exp_q.size() != 0);
        do_push = in_valid && (exp_q.size() != DEPTH);
        exp_res_valid = do_pop;
        if (do_pop) begin
          p     = exp_q.pop_front();
          r.o   = p.a | p.b;
          r.err = fault_mode;
          res_q.push_back(r);
          exp_txn = exp_txn + 2'd1;
        end
        if (do_push) begin
          p.a = in_I0;
          p.b = in_I1;
          exp_q.push_back(p);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET     = 1'b1;
    in_valid  = 1'b0;
    in_I0     = 2'b00;
    in_I1     = 2'b00;
    out_ready = 1'b0;
    step();
    mon_en = 1'b1;
    step();
    RESET = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || res_valid !== 1'b0 ||
        res_O !== 2'b00 || res_err !== 1'b0 || txn_count !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got ir=%b ov=%b rv=%b O=%b err=%b txn=%0d expected 1 0 0 00 0 0",
               in_ready, out_valid, res_valid, res_O, res_err, txn_count);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_I0     = 2'b10;
    in_I1     = 2'b01;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || I0 !== 2'b00 || I1 !== 2'b01 ||
        lifted_input0 !== 1'b1 || lifted_input1 !== 1'b0) begin
      miscompares++;
      $display("FAIL single_head: got ov=%b I0=%b I1=%b L0=%b L1=%b expected 1 00 01 1 0",
               out_valid, I0, I1, lifted_input0, lifted_input1);
    end
    step();
    vectors++;
    if (res_valid !== 1'b1 || res_O !== 2'b11 || res_err !== 1'b0 || txn_count !== 2'd1) begin
      miscompares++;
      $display("FAIL single_result: got rv=%b O=%b err=%b txn=%0d expected 1 11 0 1",
               res_valid, res_O, res_err, txn_count);
    end
    step();
    vectors++;
    if (res_valid !== 1'b0 || res_O !== 2'b11) begin
      miscompares++;
      $display("FAIL single_strobe_width: got rv=%b O=%b expected 0 11", res_valid, res_O);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_I0 = 2'b01; in_I1 = 2'b10;
    step();
    in_I0 = 2'b11; in_I1 = 2'b00;
    step();
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_in_ready: got %b expected 0", in_ready);
    end
    in_I0 = 2'b00; in_I1 = 2'b11;
    step();
    step();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || I0 !== 2'b01 || I1 !== 2'b00 ||
        lifted_input0 !== 1'b0 || lifted_input1 !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_head_stable: got ir=%b ov=%b I0=%b I1=%b L0=%b L1=%b expected 0 1 01 00 0 1",
               in_ready, out_valid, I0, I1, lifted_input0, lifted_input1);
    end
  endtask

  // Starts from a full queue; each pair is held until accepted.
  task automatic test_stream();
    logic [1:0] a_tab [4];
    logic [1:0] b_tab [4];
    bit ok;
    a_tab[0] = 2'b10; b_tab[0] = 2'b10;
    a_tab[1] = 2'b01; b_tab[1] = 2'b11;
    a_tab[2] = 2'b00; b_tab[2] = 2'b00;
    a_tab[3] = 2'b11; b_tab[3] = 2'b01;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_I0    = a_tab[i];
      in_I1    = b_tab[i];
      ok = 1'b0;
      for (int k = 0; k < 8 && !ok; k++) begin
        ok = (in_ready === 1'b1);
        step();
        vectors++;
        if (out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_occupancy: got out_valid=%b expected 1 (pair %0d)", out_valid, i);
        end
      end
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL stream_accept_timeout: got no accept expected accept (pair %0d)", i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 12 && out_valid === 1'b1; k++) step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_timeout: got out_valid=%b expected 0", out_valid);
    end
    step();
  endtask

  task automatic test_fault();
    fault_mode = 1'b1;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_I0      = 2'b01;
    in_I1      = 2'b00;
    step();
    in_valid = 1'b0;
    step();
    vectors++;
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_O !== 2'b01) begin
      miscompares++;
      $display("FAIL fault_detect: got rv=%b err=%b O=%b expected 1 1 01", res_valid, res_err, res_O);
    end
    step();
    fault_mode = 1'b0;
  endtask

  task automatic test_count_wrap();
    logic [1:0] seq [5];
    int k;
    int c2;
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
    RESET = 1'b1;
    step();
    RESET     = 1'b0;
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 14 && k < 5; c++) begin
      c2       = c;
      in_valid = (c < 5);
      in_I0    = c2[1:0];
      in_I1    = ~c2[1:0];
      step();
      if (res_valid === 1'b1) begin
        vectors++;
        if (txn_count !== seq[k]) begin
          miscompares++;
          $display("FAIL count_wrap: got %0d expected %0d (pop %0d)", txn_count, seq[k], k + 1);
        end
        k++;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (k != 5) begin
      miscompares++;
      $display("FAIL count_wrap_pops: got %0d expected 5", k);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_I0 = 2'b11; in_I1 = 2'b11;
    step();
    in_I0 = 2'b10; in_I1 = 2'b01;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    RESET     = 1'b1;
    step();
    RESET = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || res_valid !== 1'b0 || txn_count !== 2'd0 ||
        in_ready !== 1'b1 || res_O !== 2'b00 || res_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got ov=%b rv=%b txn=%0d ir=%b O=%b err=%b expected 0 0 0 1 00 0",
               out_valid, res_valid, txn_count, in_ready, res_O, res_err);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_I0     = 2'($urandom_range(0, 3));
      in_I1     = 2'($urandom_range(0, 3));
      step();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    drain();
    test_fault();
    test_count_wrap();
    test_reset_mid();
    test_random();
    @(negedge CLK);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
